// File: rtl/quiz_cfg_pkg.sv
// Shared definitions for the quiz configuration sequencer: stage encoding,
// key codes and small helpers for walking the field states.
package quiz_cfg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PLAYERS = 3'd1,
    ST_TIME    = 3'd2,
    ST_ADD     = 3'd3,
    ST_DED     = 3'd4,
    ST_DONE    = 3'd5
  } stage_t;

  localparam logic [3:0] KEY_ENTER = 4'hA;
  localparam logic [3:0] KEY_BS    = 4'hB;
  localparam logic [3:0] KEY_OK    = 4'hC;
  localparam logic [3:0] KEY_DEF   = 4'hD;
  localparam logic [3:0] KEY_ESC   = 4'hE;

  function automatic logic is_field(input stage_t s);
    return (s == ST_PLAYERS) || (s == ST_TIME) || (s == ST_ADD) || (s == ST_DED);
  endfunction

  function automatic stage_t next_field(input stage_t s);
    case (s)
      ST_PLAYERS: return ST_TIME;
      ST_TIME:    return ST_ADD;
      ST_ADD:     return ST_DED;
      default:    return ST_DONE;
    endcase
  endfunction

endpackage

// File: rtl/digit_entry.sv
// Decimal digit accumulator for one keypad field. Holds the value typed so
// far and the digit count; a digit beyond max_cnt is refused and flagged.
module digit_entry (
  input  logic       clk,
  input  logic       rst,
  input  logic       digit_valid,
  input  logic [3:0] digit,
  input  logic       clear,
  input  logic [1:0] max_cnt,
  output logic [6:0] val,
  output logic [1:0] cnt,
  output logic       overflow
);

  assign overflow = digit_valid && (cnt >= max_cnt);

  // Shift a new decimal digit in, or wipe the entry when the field is left or reset
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      val <= '0;
      cnt <= '0;
    end else if (digit_valid && !overflow) begin
      val <= val * 7'd10 + {3'b000, digit};
      cnt <= cnt + 2'd1;
    end
  end

endmodule

// File: rtl/setting_seq.sv
// Keypad-driven configuration sequencer. Walks players, answer time, add and
// deduct points through shadow registers and commits all four to cfg_* in a
// single edge, so the game FSM never sees a half-updated configuration.
module setting_seq
  import quiz_cfg_pkg::*;
#(
  parameter int MAX_PLAYERS = 4,
  parameter int TIME_W      = 8,
  parameter int TIME_MAX    = 99,
  parameter int TIME_DEF    = 30,
  parameter int PTS_W       = 4,
  parameter int PTS_MAX     = 9,
  parameter int ADD_DEF     = 1,
  parameter int DED_DEF     = 1,
  parameter int TIMEOUT_CYC = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              key_flag,
  input  logic [3:0]        key_val,
  input  logic              lock,
  output logic [2:0]        cfg_players,
  output logic [TIME_W-1:0] cfg_time,
  output logic [PTS_W-1:0]  cfg_add,
  output logic [PTS_W-1:0]  cfg_ded,
  output logic              set_done,
  output logic [2:0]        stage,
  output logic [6:0]        entry_val,
  output logic [1:0]        entry_cnt,
  output logic              err
);

  localparam logic [2:0]        PL_DEF  = 3'(MAX_PLAYERS);
  localparam logic [TIME_W-1:0] TM_DEF  = TIME_W'(TIME_DEF);
  localparam logic [PTS_W-1:0]  AD_DEF  = PTS_W'(ADD_DEF);
  localparam logic [PTS_W-1:0]  DD_DEF  = PTS_W'(DED_DEF);
  localparam logic [6:0]        PL_MAX7 = 7'(MAX_PLAYERS);
  localparam logic [6:0]        TM_MAX7 = 7'(TIME_MAX);
  localparam logic [6:0]        PT_MAX7 = 7'(PTS_MAX);
  localparam logic [6:0]        TM_DEF7 = 7'(TIME_DEF);
  localparam logic [6:0]        AD_DEF7 = 7'(ADD_DEF);
  localparam logic [6:0]        DD_DEF7 = 7'(DED_DEF);

  stage_t            state;
  logic [2:0]        sh_players, nsh_players;
  logic [TIME_W-1:0] sh_time, nsh_time;
  logic [PTS_W-1:0]  sh_add, nsh_add;
  logic [PTS_W-1:0]  sh_ded, nsh_ded;

  logic       field, timeout, cancel;
  logic       key_digit, key_bs, key_ok, key_def, key_esc;
  logic       overflow, in_range, adv, wr, err_n;
  logic [6:0] field_def, wr_val;

  assign stage     = state;
  assign field     = is_field(state);
  assign key_digit = (key_val <= 4'd9);
  assign key_bs    = (key_val == KEY_BS);
  assign key_ok    = (key_val == KEY_OK);
  assign key_def   = (key_val == KEY_DEF);
  assign key_esc   = (key_val == KEY_ESC);

  generate
    if (TIMEOUT_CYC > 0) begin : g_timeout
      localparam int             TO_W    = $clog2(TIMEOUT_CYC + 1);
      localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
      localparam logic [TO_W-1:0] TO_TOP  = TO_W'(TIMEOUT_CYC);
      logic [TO_W-1:0] idle_cnt;

      // Count keyless cycles spent in a field; any key or leaving the fields restarts it
      always_ff @(posedge clk) begin
        if (rst || key_flag || !field) idle_cnt <= '0;
        else if (idle_cnt != TO_TOP)   idle_cnt <= idle_cnt + TO_W'(1);
      end

      assign timeout = field && !key_flag && (idle_cnt == TO_LAST);
    end else begin : g_no_timeout
      assign timeout = 1'b0;
    end
  endgenerate

  assign cancel = field && (timeout || (key_flag && key_esc));

  digit_entry u_entry (
    .clk        (clk),
    .rst        (rst),
    .digit_valid(field && key_flag && key_digit),
    .digit      (key_val),
    .clear      (field && (cancel || (key_flag && (key_bs || key_ok || key_def)))),
    .max_cnt    ((state == ST_TIME) ? 2'd2 : 2'd1),
    .val        (entry_val),
    .cnt        (entry_cnt),
    .overflow   (overflow)
  );

  // Legal range and default value of the field currently being edited
  always_comb begin
    in_range  = 1'b0;
    field_def = '0;
    case (state)
      ST_PLAYERS: begin
        in_range  = (entry_val >= 7'd2) && (entry_val <= PL_MAX7);
        field_def = PL_MAX7;
      end
      ST_TIME: begin
        in_range  = (entry_val >= 7'd1) && (entry_val <= TM_MAX7);
        field_def = TM_DEF7;
      end
      ST_ADD: begin
        in_range  = (entry_val >= 7'd1) && (entry_val <= PT_MAX7);
        field_def = AD_DEF7;
      end
      ST_DED: begin
        in_range  = (entry_val <= PT_MAX7);
        field_def = DD_DEF7;
      end
      default: ;
    endcase
  end

  // Decide what a key in a field does: write the shadow, advance, or flag an error
  always_comb begin
    adv    = 1'b0;
    wr     = 1'b0;
    err_n  = 1'b0;
    wr_val = entry_val;
    if (field && key_flag && !cancel) begin
      if (key_digit) begin
        err_n = overflow;
      end else if (key_ok) begin
        if (entry_cnt == 2'd0) begin
          adv = 1'b1;
        end else if (in_range) begin
          wr  = 1'b1;
          adv = 1'b1;
        end else begin
          err_n = 1'b1;
        end
      end else if (key_def) begin
        wr     = 1'b1;
        wr_val = field_def;
        adv    = 1'b1;
      end
    end
  end

  assign nsh_players = (wr && state == ST_PLAYERS) ? wr_val[2:0]      : sh_players;
  assign nsh_time    = (wr && state == ST_TIME)    ? TIME_W'(wr_val)  : sh_time;
  assign nsh_add     = (wr && state == ST_ADD)     ? PTS_W'(wr_val)   : sh_add;
  assign nsh_ded     = (wr && state == ST_DED)     ? PTS_W'(wr_val)   : sh_ded;

  // Stage FSM with shadow registers and the single-edge commit to cfg_*
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      cfg_players <= PL_DEF;
      cfg_time    <= TM_DEF;
      cfg_add     <= AD_DEF;
      cfg_ded     <= DD_DEF;
      sh_players  <= PL_DEF;
      sh_time     <= TM_DEF;
      sh_add      <= AD_DEF;
      sh_ded      <= DD_DEF;
      set_done    <= 1'b0;
      err         <= 1'b0;
    end else begin
      err <= 1'b0;
      if (cancel) begin
        sh_players <= cfg_players;
        sh_time    <= cfg_time;
        sh_add     <= cfg_add;
        sh_ded     <= cfg_ded;
        state      <= ST_DONE;
        set_done   <= 1'b1;
      end else if (field) begin
        sh_players <= nsh_players;
        sh_time    <= nsh_time;
        sh_add     <= nsh_add;
        sh_ded     <= nsh_ded;
        err        <= err_n;
        if (adv) begin
          if (state == ST_DED) begin
            cfg_players <= nsh_players;
            cfg_time    <= nsh_time;
            cfg_add     <= nsh_add;
            cfg_ded     <= nsh_ded;
            state       <= ST_DONE;
            set_done    <= 1'b1;
          end else begin
            state <= next_field(state);
          end
        end
      end else if (key_flag) begin
        if (state == ST_IDLE) begin
          if (key_val == KEY_ENTER) begin
            state <= ST_PLAYERS;
          end else begin
            state    <= ST_DONE;
            set_done <= 1'b1;
          end
        end else if (!lock && key_val == KEY_ENTER) begin
          state    <= ST_PLAYERS;
          set_done <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_setting_seq.sv
// Bench for setting_seq: a hand-written vector table of the configuration
// scenarios, timeout and reset sequences, then randomized keys checked
// against a field-array reference model.
module tb_setting_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key_flag = 1'b0;
  logic [3:0] key_val = 4'd0;
  logic       lock = 1'b0;
  logic [2:0] cfg_players;
  logic [7:0] cfg_time;
  logic [3:0] cfg_add, cfg_ded;
  logic       set_done, err;
  logic [2:0] stage;
  logic [6:0] entry_val;
  logic [1:0] entry_cnt;

  setting_seq #(.TIMEOUT_CYC(16)) dut (
    .clk(clk), .rst(rst), .key_flag(key_flag), .key_val(key_val), .lock(lock),
    .cfg_players(cfg_players), .cfg_time(cfg_time), .cfg_add(cfg_add), .cfg_ded(cfg_ded),
    .set_done(set_done), .stage(stage), .entry_val(entry_val), .entry_cnt(entry_cnt),
    .err(err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: fields indexed 0..3 = players, time, add, ded
  int m_stage, m_done, m_err, m_idle, e_val, e_cnt;
  int cf[4];
  int sh[4];
  int defv[4] = '{4, 30, 1, 1};
  int lo[4]   = '{2, 1, 1, 0};
  int hi[4]   = '{4, 99, 9, 9};

  typedef struct {
    bit rst_before;
    int key;
    bit lk;
    int st;
    bit done;
    bit er;
    int cnt;
    int val;
    int pl, tm, ad, dd;
  } vec_t;

  vec_t tbl[$];

  task automatic cmp(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void modelReset();
    m_stage = 0; m_done = 0; m_err = 0; m_idle = 0; e_val = 0; e_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      cf[i] = defv[i];
      sh[i] = defv[i];
    end
  endfunction

  function automatic void modelCancel();
    for (int i = 0; i < 4; i++) sh[i] = cf[i];
    e_val = 0; e_cnt = 0; m_stage = 5; m_done = 1;
  endfunction

  function automatic void modelAdvance();
    e_val = 0; e_cnt = 0; m_idle = 0;
    if (m_stage == 4) begin
      for (int i = 0; i < 4; i++) cf[i] = sh[i];
      m_stage = 5; m_done = 1;
    end else begin
      m_stage++;
    end
  endfunction

  function automatic void modelStep(input bit kf, input int key, input bit lk);
    int f;
    m_err = 0;
    f = m_stage - 1;
    if (m_stage >= 1 && m_stage <= 4) begin
      if (!kf) begin
        m_idle++;
        if (m_idle == 16) modelCancel();
      end else begin
        m_idle = 0;
        if (key <= 9) begin
          if (e_cnt == ((m_stage == 2) ? 2 : 1)) m_err = 1;
          else begin e_val = e_val * 10 + key; e_cnt++; end
        end else if (key == 11) begin
          e_val = 0; e_cnt = 0;
        end else if (key == 12) begin
          if (e_cnt == 0) modelAdvance();
          else if (e_val >= lo[f] && e_val <= hi[f]) begin sh[f] = e_val; modelAdvance(); end
          else begin m_err = 1; e_val = 0; e_cnt = 0; end
        end else if (key == 13) begin
          sh[f] = defv[f]; modelAdvance();
        end else if (key == 14) begin
          modelCancel();
        end
      end
    end else if (m_stage == 0) begin
      if (kf) begin
        if (key == 10) begin m_stage = 1; m_idle = 0; end
        else begin m_stage = 5; m_done = 1; end
      end
    end else if (kf && !lk && key == 10) begin
      m_stage = 1; m_done = 0; m_idle = 0;
    end
  endfunction

  task automatic checkOutput();
    cmp("stage", int'(stage), m_stage);
    cmp("set_done", int'(set_done), m_done);
    cmp("err", int'(err), m_err);
    cmp("entry_val", int'(entry_val), e_val);
    cmp("entry_cnt", int'(entry_cnt), e_cnt);
    cmp("cfg_players", int'(cfg_players), cf[0]);
    cmp("cfg_time", int'(cfg_time), cf[1]);
    cmp("cfg_add", int'(cfg_add), cf[2]);
    cmp("cfg_ded", int'(cfg_ded), cf[3]);
  endtask

  task automatic applyStimulus(input bit kf, input int key, input bit lk);
    key_flag = kf;
    key_val  = 4'(key);
    lock     = lk;
    @(posedge clk);
    modelStep(kf, key, lk);
    @(negedge clk);
    checkOutput();
  endtask

  task automatic doReset();
    key_flag = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    modelReset();
    @(negedge clk);
    rst = 1'b0;
    checkOutput();
  endtask

  task automatic addVec(input bit r, input int key, input bit lk, input int st, input bit done,
                        input bit er, input int cnt, input int val,
                        input int pl, input int tm, input int ad, input int dd);
    vec_t v;
    v.rst_before = r; v.key = key; v.lk = lk; v.st = st; v.done = done; v.er = er;
    v.cnt = cnt; v.val = val; v.pl = pl; v.tm = tm; v.ad = ad; v.dd = dd;
    tbl.push_back(v);
  endtask

  initial begin
    // Any key other than A from IDLE goes straight to DONE with defaults
    addVec(1, 5,  0, 5, 1, 0, 0, 0,  4, 30, 1, 1);
    // Full walk: players 3, time 45, add 2, ded 0, committed on the last C
    addVec(1, 10, 0, 1, 0, 0, 0, 0,  4, 30, 1, 1);
    addVec(0, 3,  0, 1, 0, 0, 1, 3,  4, 30, 1, 1);
    addVec(0, 12, 0, 2, 0, 0, 0, 0,  4, 30, 1, 1);
    addVec(0, 4,  0, 2, 0, 0, 1, 4,  4, 30, 1, 1);
    addVec(0, 5,  0, 2, 0, 0, 2, 45, 4, 30, 1, 1);
    addVec(0, 12, 0, 3, 0, 0, 0, 0,  4, 30, 1, 1);
    addVec(0, 2,  0, 3, 0, 0, 1, 2,  4, 30, 1, 1);
    addVec(0, 12, 0, 4, 0, 0, 0, 0,  4, 30, 1, 1);
    addVec(0, 0,  0, 4, 0, 0, 1, 0,  4, 30, 1, 1);
    addVec(0, 12, 0, 5, 1, 0, 0, 0,  3, 45, 2, 0);
    // Reconfigure: players 5 rejected, backspace, players 2, time 99 with overflow digit
    addVec(0, 10, 0, 1, 0, 0, 0, 0,  3, 45, 2, 0);
    addVec(0, 5,  0, 1, 0, 0, 1, 5,  3, 45, 2, 0);
    addVec(0, 12, 0, 1, 0, 1, 0, 0,  3, 45, 2, 0);
    addVec(0, 1,  0, 1, 0, 0, 1, 1,  3, 45, 2, 0);
    addVec(0, 11, 0, 1, 0, 0, 0, 0,  3, 45, 2, 0);
    addVec(0, 2,  0, 1, 0, 0, 1, 2,  3, 45, 2, 0);
    addVec(0, 12, 0, 2, 0, 0, 0, 0,  3, 45, 2, 0);
    addVec(0, 9,  0, 2, 0, 0, 1, 9,  3, 45, 2, 0);
    addVec(0, 9,  0, 2, 0, 0, 2, 99, 3, 45, 2, 0);
    addVec(0, 7,  0, 2, 0, 1, 2, 99, 3, 45, 2, 0);
    addVec(0, 12, 0, 3, 0, 0, 0, 0,  3, 45, 2, 0);
    addVec(0, 13, 0, 4, 0, 0, 0, 0,  3, 45, 2, 0);
    addVec(0, 13, 0, 5, 1, 0, 0, 0,  2, 99, 1, 1);
    // Time of 0 is out of range, then cancel keeps the committed config
    addVec(0, 10, 0, 1, 0, 0, 0, 0,  2, 99, 1, 1);
    addVec(0, 12, 0, 2, 0, 0, 0, 0,  2, 99, 1, 1);
    addVec(0, 0,  0, 2, 0, 0, 1, 0,  2, 99, 1, 1);
    addVec(0, 12, 0, 2, 0, 1, 0, 0,  2, 99, 1, 1);
    addVec(0, 14, 0, 5, 1, 0, 0, 0,  2, 99, 1, 1);
    addVec(0, 10, 0, 1, 0, 0, 0, 0,  2, 99, 1, 1);
    addVec(0, 2,  0, 1, 0, 0, 1, 2,  2, 99, 1, 1);
    addVec(0, 12, 0, 2, 0, 0, 0, 0,  2, 99, 1, 1);
    addVec(0, 6,  0, 2, 0, 0, 1, 6,  2, 99, 1, 1);
    addVec(0, 0,  0, 2, 0, 0, 2, 60, 2, 99, 1, 1);
    addVec(0, 14, 0, 5, 1, 0, 0, 0,  2, 99, 1, 1);
    // Lock holds DONE; unlocking lets A reopen configuration
    addVec(0, 10, 1, 5, 1, 0, 0, 0,  2, 99, 1, 1);
    addVec(0, 3,  1, 5, 1, 0, 0, 0,  2, 99, 1, 1);
    addVec(0, 10, 0, 1, 0, 0, 0, 0,  2, 99, 1, 1);

    modelReset();
    @(negedge clk);
    doReset();
    cmp("reset_stage", int'(stage), 0);
    cmp("reset_time", int'(cfg_time), 30);

    foreach (tbl[i]) begin
      if (tbl[i].rst_before) doReset();
      applyStimulus(1'b1, tbl[i].key, tbl[i].lk);
      cmp($sformatf("tbl%0d_stage", i), int'(stage), tbl[i].st);
      cmp($sformatf("tbl%0d_done", i), int'(set_done), int'(tbl[i].done));
      cmp($sformatf("tbl%0d_err", i), int'(err), int'(tbl[i].er));
      cmp($sformatf("tbl%0d_cnt", i), int'(entry_cnt), tbl[i].cnt);
      cmp($sformatf("tbl%0d_val", i), int'(entry_val), tbl[i].val);
      cmp($sformatf("tbl%0d_players", i), int'(cfg_players), tbl[i].pl);
      cmp($sformatf("tbl%0d_time", i), int'(cfg_time), tbl[i].tm);
      cmp($sformatf("tbl%0d_add", i), int'(cfg_add), tbl[i].ad);
      cmp($sformatf("tbl%0d_ded", i), int'(cfg_ded), tbl[i].dd);
    end

    // Idle timeout from PLAYERS: 15 quiet cycles stay, the 16th cancels
    for (int i = 0; i < 15; i++) applyStimulus(1'b0, 0, 1'b0);
    cmp("timeout_before", int'(stage), 1);
    applyStimulus(1'b0, 0, 1'b0);
    cmp("timeout_fire", int'(stage), 5);
    cmp("timeout_done", int'(set_done), 1);
    cmp("timeout_players", int'(cfg_players), 2);

    // An ignored key still restarts the idle count
    applyStimulus(1'b1, 10, 1'b0);
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 0, 1'b0);
    applyStimulus(1'b1, 15, 1'b0);
    for (int i = 0; i < 15; i++) applyStimulus(1'b0, 0, 1'b0);
    cmp("reload_before", int'(stage), 1);
    applyStimulus(1'b0, 0, 1'b0);
    cmp("reload_fire", int'(stage), 5);

    // Reset in the middle of an entry
    applyStimulus(1'b1, 10, 1'b0);
    applyStimulus(1'b1, 3, 1'b0);
    doReset();
    cmp("rst_mid_stage", int'(stage), 0);
    cmp("rst_mid_cnt", int'(entry_cnt), 0);
    cmp("rst_mid_players", int'(cfg_players), 4);
    cmp("rst_mid_time", int'(cfg_time), 30);

    // Randomized keys against the model
    for (int n = 0; n < 3000; n++) begin
      int r, key;
      bit kf, lk;
      r = $urandom_range(0, 199);
      lk = lock;
      if ($urandom_range(0, 19) == 0) lk = ~lock;
      if (r == 0) begin
        doReset();
      end else if (r < 5) begin
        for (int i = 0; i < 18; i++) applyStimulus(1'b0, 0, lk);
      end else begin
        kf = ($urandom_range(0, 9) < 6);
        if ($urandom_range(0, 3) == 0) key = $urandom_range(10, 14);
        else key = $urandom_range(0, 15);
        applyStimulus(kf, key, lk);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
